// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_pkg
//  Description : Shared definitions for the condition unit and its consumers:
//                condition-code encodings, flag bit positions, flag struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // ARM-style condition field encodings; 4'b1111 is treated as "never".
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Purely combinational condition evaluator: condition field
//                plus {N,Z,C,V} flags -> pass. Shared with the trace unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    import cond_pkg::*;

    flags_t w_f;
    assign w_f = flags;

    // Decode the condition field against the flag struct.
    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ:      pass = w_f.z;
            NE:      pass = ~w_f.z;
            CS:      pass = w_f.c;
            CC:      pass = ~w_f.c;
            MI:      pass = w_f.n;
            PL:      pass = ~w_f.n;
            VS:      pass = w_f.v;
            VC:      pass = ~w_f.v;
            HI:      pass = w_f.c & ~w_f.z;
            LS:      pass = ~w_f.c | w_f.z;
            GE:      pass = (w_f.n == w_f.v);
            LT:      pass = (w_f.n != w_f.v);
            GT:      pass = ~w_f.z & (w_f.n == w_f.v);
            LE:      pass = w_f.z | (w_f.n != w_f.v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;   // NV: never executes
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cond_unit
//  Description : Execute-stage condition unit. Holds the architectural flag
//                register, evaluates the condition field, gates branch /
//                register-write / memory-write enables, registers them into
//                the memory stage and keeps saturating executed/annulled
//                event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_e,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       cond_e,
    input  logic [1:0]       flag_w_e,
    input  logic             pcs_e,
    input  logic             reg_w_e,
    input  logic             mem_w_e,
    input  logic             no_write_e,
    input  logic [3:0]       alu_flags_e,
    output logic [3:0]       flags_o,
    output logic             cond_ex_e,
    output logic             pcsrc_e,
    output logic             valid_m,
    output logic             pcs_m,
    output logic             reg_w_m,
    output logic             mem_w_m,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] annul_cnt
);
    import cond_pkg::*;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [3:0]       r_flags;
    logic             r_valid_m;
    logic             r_pcs_m;
    logic             r_reg_w_m;
    logic             r_mem_w_m;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_annul_cnt;

    logic w_go;
    logic w_pass;
    logic w_exec;
    logic w_annul;

    // Stall wins over a plain valid; flush wins over stall (both kill go).
    assign w_go    = valid_e & ~stall_e & ~flush_e;
    assign w_exec  = w_go & w_pass;
    assign w_annul = w_go & ~w_pass;

    // Condition is evaluated on the committed flags only: no ALU bypass.
    cond_check u_cond_check (
        .cond  (cond_e),
        .flags (r_flags),
        .pass  (w_pass)
    );

    assign cond_ex_e = w_pass;
    assign pcsrc_e   = w_exec & pcs_e;

    // Flag register: N,Z and C,V pairs written independently by executed ops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flags <= RESET_FLAGS;
        end else if (w_exec) begin
            if (flag_w_e[1]) begin
                r_flags[c_flag_n] <= alu_flags_e[c_flag_n];
                r_flags[c_flag_z] <= alu_flags_e[c_flag_z];
            end
            if (flag_w_e[0]) begin
                r_flags[c_flag_c] <= alu_flags_e[c_flag_c];
                r_flags[c_flag_v] <= alu_flags_e[c_flag_v];
            end
        end
    end

    // Execute->memory pipeline register; bubbles fall out of w_go being low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid_m <= 1'b0;
            r_pcs_m   <= 1'b0;
            r_reg_w_m <= 1'b0;
            r_mem_w_m <= 1'b0;
        end else begin
            r_valid_m <= w_go;
            r_pcs_m   <= w_exec & pcs_e;
            r_reg_w_m <= w_exec & reg_w_e & ~no_write_e;
            r_mem_w_m <= w_exec & mem_w_e;
        end
    end

    // Saturating executed / annulled event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_exec_cnt  <= '0;
            r_annul_cnt <= '0;
        end else begin
            if (w_exec && (r_exec_cnt != c_cnt_max)) begin
                r_exec_cnt <= r_exec_cnt + CNT_W'(1);
            end
            if (w_annul && (r_annul_cnt != c_cnt_max)) begin
                r_annul_cnt <= r_annul_cnt + CNT_W'(1);
            end
        end
    end

    assign flags_o   = r_flags;
    assign valid_m   = r_valid_m;
    assign pcs_m     = r_pcs_m;
    assign reg_w_m   = r_reg_w_m;
    assign mem_w_m   = r_mem_w_m;
    assign exec_cnt  = r_exec_cnt;
    assign annul_cnt = r_annul_cnt;

endmodule : cond_unit
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_unit
//  Description : Directed self-checking bench for cond_unit (CNT_W = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          valid_e, stall_e, flush_e;
    logic [3:0]    cond_e;
    logic [1:0]    flag_w_e;
    logic          pcs_e, reg_w_e, mem_w_e, no_write_e;
    logic [3:0]    alu_flags_e;
    logic [3:0]    flags_o;
    logic          cond_ex_e, pcsrc_e;
    logic          valid_m, pcs_m, reg_w_m, mem_w_m;
    logic [CW-1:0] exec_cnt, annul_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cond_unit #(.RESET_FLAGS(4'b0000), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_e     (valid_e),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .cond_e      (cond_e),
        .flag_w_e    (flag_w_e),
        .pcs_e       (pcs_e),
        .reg_w_e     (reg_w_e),
        .mem_w_e     (mem_w_e),
        .no_write_e  (no_write_e),
        .alu_flags_e (alu_flags_e),
        .flags_o     (flags_o),
        .cond_ex_e   (cond_ex_e),
        .pcsrc_e     (pcsrc_e),
        .valid_m     (valid_m),
        .pcs_m       (pcs_m),
        .reg_w_m     (reg_w_m),
        .mem_w_m     (mem_w_m),
        .exec_cnt    (exec_cnt),
        .annul_cnt   (annul_cnt)
    );

    always #5 clk = ~clk;

    // Reference condition table, written straight from the ARM definitions.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return ~z;
            4'd2:  return cf;
            4'd3:  return ~cf;
            4'd4:  return n;
            4'd5:  return ~n;
            4'd6:  return v;
            4'd7:  return ~v;
            4'd8:  return cf & ~z;
            4'd9:  return ~cf | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return ~z & (n == v);
            4'd13: return z | (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_e = 0; stall_e = 0; flush_e = 0; cond_e = 4'd14; flag_w_e = 2'b00;
        pcs_e = 0; reg_w_e = 0; mem_w_e = 0; no_write_e = 0; alu_flags_e = 4'b0000;
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        reset_n = 1;
        idle();
    endtask

    task automatic test_reset();
        reset_n = 0;
        for (int i = 0; i < 2; i++) begin
            {valid_e, stall_e, flush_e, pcs_e, reg_w_e, mem_w_e, no_write_e} = 7'($urandom);
            valid_e = 1; stall_e = 0; flush_e = 0;   // a live instruction must still be discarded
            cond_e = 4'd14; flag_w_e = 2'b11; alu_flags_e = 4'($urandom) | 4'b0001;
            step();
        end
        n_checks++; if (flags_o !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags_o); end
        n_checks++; if ({valid_m, pcs_m, reg_w_m, mem_w_m} !== 4'b0000) begin n_fail++; $display("FAIL reset_m: got %b want 0000", {valid_m, pcs_m, reg_w_m, mem_w_m}); end
        n_checks++; if (exec_cnt !== 0 || annul_cnt !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", exec_cnt, annul_cnt); end
        reset_n = 1;
        idle();
    endtask

    task automatic test_cmp_beq();
        do_reset();
        valid_e = 1; cond_e = 4'd14; flag_w_e = 2'b11; no_write_e = 1; reg_w_e = 1; alu_flags_e = 4'b0100;
        step();
        n_checks++; if (reg_w_m !== 1'b0) begin n_fail++; $display("FAIL cmp_reg_w_m: got %b want 0", reg_w_m); end
        n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL cmp_valid_m: got %b want 1", valid_m); end
        n_checks++; if (flags_o !== 4'b0100) begin n_fail++; $display("FAIL cmp_flags: got %b want 0100", flags_o); end
        idle();
        valid_e = 1; cond_e = 4'd0; pcs_e = 1; alu_flags_e = 4'b0000;
        #1;
        n_checks++; if (pcsrc_e !== 1'b1) begin n_fail++; $display("FAIL beq_pcsrc: got %b want 1", pcsrc_e); end
        step();
        n_checks++; if (pcs_m !== 1'b1) begin n_fail++; $display("FAIL beq_pcs_m: got %b want 1", pcs_m); end
        n_checks++; if (exec_cnt !== 4'd2) begin n_fail++; $display("FAIL beq_exec_cnt: got %0d want 2", exec_cnt); end
        idle();
    endtask

    task automatic test_partial_flags();
        do_reset();
        valid_e = 1; cond_e = 4'd14; flag_w_e = 2'b11; alu_flags_e = 4'b1111;
        step();
        n_checks++; if (flags_o !== 4'b1111) begin n_fail++; $display("FAIL partial_setup: got %b want 1111", flags_o); end
        flag_w_e = 2'b10; alu_flags_e = 4'b0000;
        step();
        n_checks++; if (flags_o !== 4'b0011) begin n_fail++; $display("FAIL partial_nz: got %b want 0011", flags_o); end
        flag_w_e = 2'b01; alu_flags_e = 4'b1100;
        step();
        n_checks++; if (flags_o !== 4'b0000) begin n_fail++; $display("FAIL partial_cv: got %b want 0000", flags_o); end
        idle();
    endtask

    task automatic test_annul();
        do_reset();
        valid_e = 1; cond_e = 4'd0; mem_w_e = 1; flag_w_e = 2'b11; alu_flags_e = 4'b1111;
        #1;
        n_checks++; if (cond_ex_e !== 1'b0) begin n_fail++; $display("FAIL annul_cond_ex: got %b want 0", cond_ex_e); end
        step();
        n_checks++; if ({valid_m, mem_w_m} !== 2'b10) begin n_fail++; $display("FAIL annul_m: got valid/mem %b want 10", {valid_m, mem_w_m}); end
        n_checks++; if (flags_o !== 4'b0000) begin n_fail++; $display("FAIL annul_flags: got %b want 0000", flags_o); end
        n_checks++; if (annul_cnt !== 4'd1 || exec_cnt !== 4'd0) begin n_fail++; $display("FAIL annul_cnt: got a=%0d e=%0d want a=1 e=0", annul_cnt, exec_cnt); end
        idle();
    endtask

    task automatic test_stall_flush();
        do_reset();
        valid_e = 1; cond_e = 4'd14; mem_w_e = 1; stall_e = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({valid_m, mem_w_m} !== 2'b00 || exec_cnt !== 4'd0) begin n_fail++; $display("FAIL stall_bubble: cyc %0d got vm/mw %b cnt %0d want 00 0", i, {valid_m, mem_w_m}, exec_cnt); end
        end
        stall_e = 0;
        step();
        n_checks++; if (mem_w_m !== 1'b1 || exec_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_release: got mw %b cnt %0d want 1 1", mem_w_m, exec_cnt); end
        idle();
        step();
        n_checks++; if (mem_w_m !== 1'b0 || exec_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_once: got mw %b cnt %0d want 0 1", mem_w_m, exec_cnt); end
        valid_e = 1; cond_e = 4'd14; mem_w_e = 1; pcs_e = 1; flag_w_e = 2'b11; alu_flags_e = 4'b1010; flush_e = 1; stall_e = 1;
        #1;
        n_checks++; if (pcsrc_e !== 1'b0) begin n_fail++; $display("FAIL flush_pcsrc: got %b want 0", pcsrc_e); end
        step();
        n_checks++; if (flags_o !== 4'b0000 || valid_m !== 1'b0 || mem_w_m !== 1'b0) begin n_fail++; $display("FAIL flush_state: got flags %b vm %b mw %b want 0000 0 0", flags_o, valid_m, mem_w_m); end
        n_checks++; if (exec_cnt !== 4'd1 || annul_cnt !== 4'd0) begin n_fail++; $display("FAIL flush_cnt: got e=%0d a=%0d want e=1 a=0", exec_cnt, annul_cnt); end
        idle();
    endtask

    task automatic test_cond_table();
        logic [3:0] fv;
        logic [3:0] cv;
        do_reset();
        for (int f = 0; f < 16; f++) begin
            fv = 4'(f);
            valid_e = 1; cond_e = 4'd14; flag_w_e = 2'b11; alu_flags_e = fv;
            step();
            idle();
            for (int c = 0; c < 16; c++) begin
                cv = 4'(c);
                cond_e = cv;
                #1;
                n_checks++;
                if (cond_ex_e !== ref_cond(cv, fv)) begin
                    n_fail++;
                    $display("FAIL cond_table: cond %b flags %b got %b want %b", cv, fv, cond_ex_e, ref_cond(cv, fv));
                end
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        valid_e = 1; cond_e = 4'd14;
        for (int i = 0; i < 20; i++) step();
        n_checks++; if (exec_cnt !== 4'd15) begin n_fail++; $display("FAIL exec_sat: got %0d want 15", exec_cnt); end
        step();
        n_checks++; if (exec_cnt !== 4'd15) begin n_fail++; $display("FAIL exec_hold: got %0d want 15", exec_cnt); end
        cond_e = 4'd15;
        for (int i = 0; i < 18; i++) step();
        n_checks++; if (annul_cnt !== 4'd15 || exec_cnt !== 4'd15) begin n_fail++; $display("FAIL annul_sat: got a=%0d e=%0d want 15 15", annul_cnt, exec_cnt); end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 0;
        test_reset();
        test_cmp_beq();
        test_partial_flags();
        test_annul();
        test_stall_flush();
        test_cond_table();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cond_unit
`default_nettype wire

// File: doc/cond_unit.md
# cond_unit

Condition unit for the pipelined datapath; it consumes the 4-bit `{N,Z,C,V}` flag vector produced by the ALU in the execute stage. It holds the architectural flag register and evaluates the instruction's 4-bit condition field against it. It gates branch, register-write and memory-write enables, and registers the gated controls into the memory stage. Two saturating event counters (executed, annulled) support performance debug.

## Interface
- `RESET_FLAGS`, default 4'b0000: value loaded into the flag register on reset, as `{N,Z,C,V}`.
- `CNT_W`, default 16: width of each event counter.

- `clk` input 1: single clock, all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `valid_e` input 1: the execute stage holds a real instruction.
- `stall_e` input 1: the execute instruction is held and re-presented next cycle; no side effects this cycle.
- `flush_e` input 1: the execute instruction is killed.
- `cond_e` input 4: ARM condition field.
- `flag_w_e` input 2: [1] writes N,Z; [0] writes C,V.
- `pcs_e`, `reg_w_e`, `mem_w_e` input 1 each: ungated control enables.
- `no_write_e` input 1: compare-class instruction; suppresses register write.
- `alu_flags_e` input 4: `{N,Z,C,V}` from the ALU this cycle.
- `flags_o` output 4: current flag register.
- `cond_ex_e` output 1: condition passes (combinational).
- `pcsrc_e` output 1: taken-branch redirect (combinational).
- `valid_m`, `pcs_m`, `reg_w_m`, `mem_w_m` output 1 each: registered gated controls.
- `exec_cnt`, `annul_cnt` output CNT_W each: saturating counters.

## Operation
- `go = valid_e & ~stall_e & ~flush_e`.
- `cond_ex_e` is computed from `flags_o`, never from `alu_flags_e`:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 = 0 (never).
- `pcsrc_e = go & cond_ex_e & pcs_e`.
- Flag register update, when `go & cond_ex_e`:
  - `flag_w_e[1]` loads N,Z from `alu_flags_e[3:2]`.
  - `flag_w_e[0]` loads C,V from `alu_flags_e[1:0]`.
  - Bits not selected hold their value.
- M register loads every cycle with no enable:
  - `valid_m = go`
  - `pcs_m = go & cond_ex_e & pcs_e`
  - `reg_w_m = go & cond_ex_e & reg_w_e & ~no_write_e`
  - `mem_w_m = go & cond_ex_e & mem_w_e`
- Stall and flush both inject a bubble into M (all M outputs 0). A stalled instruction produces side effects exactly once, in the cycle it is presented with `stall_e=0`.
- Counters:
  - `exec_cnt` increments when `go & cond_ex_e`.
  - `annul_cnt` increments when `go & ~cond_ex_e`.
  - Both saturate at all-ones; no wrap.
- `flush_e` and `stall_e` together: treated as flush.

## Timing
- Reset (`reset_n=0` at an edge) loads:
  - `flags_o = RESET_FLAGS`
  - `valid_m = pcs_m = reg_w_m = mem_w_m = 0`
  - both counters 0
- Reset overrides all other inputs in that cycle. Reset asserted mid-instruction discards that instruction.
- `cond_ex_e` and `pcsrc_e` have zero latency: combinational in the execute cycle.
- Flags written by instruction k are visible to `cond_ex_e` of instruction k+1 in the next cycle, with no bypass.
- M outputs have 1-cycle latency.
- Inputs other than `reset_n` are ignored during reset.

## Structure
- Shared package `cond_pkg`:
  - `cond_e` enum with the 15 mnemonics plus NV=4'b1111.
  - Flag bit index constants: N=3, Z=2, C=1, V=0.
  - `flags_t` packed struct `{n,z,c,v}`.
- One sub-module, `cond_check`: purely combinational, cond + flags -> pass. It is reused by the debug trace unit.
- Counters and registers stay in `cond_unit`.

## Test plan
- Reset: hold `reset_n=0` for 2 cycles with random inputs -> `flags_o=0000`, all M outputs 0, `exec_cnt=annul_cnt=0`.
- CMP then BEQ:
  - Cycle 0: `cond=AL`, `flag_w=11`, `no_write=1`, `reg_w=1`, `alu_flags=0100` -> `reg_w_m=0` next cycle, `flags_o=0100`.
  - Cycle 1: `cond=EQ`, `pcs=1` -> `pcsrc_e=1`, `pcs_m=1`.
- Partial flag write: flags=1111, then AL with `flag_w=10`, `alu_flags=0000` -> `flags_o=0011`.
- Annul: flags=0000, `cond=EQ`, `mem_w=1`, `flag_w=11`, `alu_flags=1111` -> `mem_w_m=0`, `valid_m=1`, flags stay 0000, `annul_cnt` +1.
- Stall/flush:
  - AL store with `stall_e=1` for 3 cycles, then 0 -> `mem_w_m=1` exactly once, `exec_cnt` +1.
  - Same instruction with `flush_e=1` -> no flag change, `valid_m=0`, counters unchanged.
- All 16 conditions × all 16 flag values -> `cond_ex_e` matches the table; NV is always 0. Counters with `CNT_W=4`: 20 executes -> `exec_cnt=15`, held.
